pcie_dest_drain: RTL and testbench
==================================

// Module: pcie_dest_drain
// PURPOSE
//  Drains the two destination FIFOs (D0, D1) at the output of the transaction layer.
//  Pops whichever FIFO advertises can_pop, round-robin when both do.
//  Merges the words into one valid/ready stream tagged with the source FIFO.
//  Keeps a free-running, wrapping word counter per destination.
// PARAMETERS
//  BITNUMBER  6  word width; matches the transaction-layer FIFOs
//  COUNT_W    8  width of each per-destination word counter
// PORTS
//  clk          in   1          single clock, rising edge
//  reset        in   1          synchronous, active-high
//  D0_can_pop   in   1          D0 FIFO holds at least one readable word
//  D1_can_pop   in   1          D1 FIFO holds at least one readable word
//  data_out0    in   BITNUMBER  D0 FIFO read data, valid the cycle after pop_D0
//  data_out1    in   BITNUMBER  D1 FIFO read data, valid the cycle after pop_D1
//  out_ready    in   1          downstream accepts the head word this cycle
//  pop_D0       out  1          read strobe to D0 FIFO
//  pop_D1       out  1          read strobe to D1 FIFO
//  out_data     out  BITNUMBER  head word of the merged stream
//  out_dest     out  1          0 = word came from D0, 1 = word came from D1
//  out_valid    out  1          out_data/out_dest are valid
//  cnt_D0       out  COUNT_W    number of words accepted downstream from D0, mod 2^COUNT_W
//  cnt_D1       out  COUNT_W    number of words accepted downstream from D1, mod 2^COUNT_W
//  idle         out  1          no pop in flight, skid buffer empty, and neither can_pop set
// BEHAVIOUR
//  Reset (synchronous, active-high)
//  - All outputs are 0.
//  - Round-robin pointer is set so that D0 wins first.
//  - Skid buffer is emptied and the in-flight flag is cleared.
//  - Reset overrides everything in the same cycle: a word in flight is dropped.
//  Timing and stream
//  - FIFO read latency is 1. A pop in cycle N captures data_outX at edge N+1 into
//    a 2-entry skid buffer (FIFO order), tagged with its source.
//  - out_valid = buffer not empty. out_data/out_dest = buffer head.
//  - Transfer happens when out_valid && out_ready. The head leaves at that edge.
//  - Head is stable while out_valid && !out_ready.
//  Pop issue
//  - Credit rule: issue a pop only if (buffer occupancy + inflight) < 2, counted
//    after this cycle's transfer. A stalled out_ready can therefore never overflow
//    the buffer.
//  - At most one pop per cycle. pop_D0 and pop_D1 are never high together.
//  - Arbiter states, using last-granted pointer G:
//      G_D0: last grant went to D0; D1 has priority next.
//      G_D1: last grant went to D1; D0 has priority next.
//  - Grant rules:
//      only one can_pop high -> pop that FIFO.
//      both high -> pop the priority side.
//      G moves only on an actual grant.
//      neither high -> no pop; G holds.
//  - Pops are combinational from can_pop, registered state and out_ready.
//    The read strobe is asserted in the same cycle.
//  - Steady-state throughput is 1 word/cycle when out_ready is held high.
//  Counters and idle
//  - cnt_Dx increments on each transfer whose out_dest = x.
//  - Counters wrap from 2^COUNT_W-1 to 0 with no saturation and no flag.
//  - idle is a registered output, updated every cycle.
//  Boundary cases
//  - Buffer full and out_ready=0 -> no pop, even if can_pop is high.
//  - Buffer full and out_ready=1 -> transfer and pop in the same cycle. This is legal.
//  - A can_pop that deasserts in the cycle after a pop does not cancel the
//    in-flight capture.
// STRUCTURE
//  - Shared package: source-tag constants DEST_D0 = 1'b0 and DEST_D1 = 1'b1,
//    and the skid depth constant SKID_DEPTH = 2.
//  - One sub-module: pcie_rr_arb2 (2-way round-robin grant with pointer).
//  - Skid buffer, credit logic and counters live in the top module.
// TESTING
//  1. Reset held 3 cycles with both can_pop high -> no pops; all outputs 0.
//     After release, D0 is popped first.
//  2. Only D1_can_pop, data 6'h15, out_ready=1 -> pop_D1 in cycle N;
//     out_valid, out_data=6'h15, out_dest=1 in N+1; cnt_D1=1.
//  3. Both can_pop high continuously, out_ready=1 -> pops alternate D0,D1,D0,D1
//     at 1/cycle; cnt_D0 and cnt_D1 differ by at most 1.
//  4. out_ready=0 for 10 cycles with both can_pop high -> exactly 2 pops;
//     head word is stable. Raise out_ready -> both words emerge in pop order
//     with no loss or duplication.
//  5. COUNT_W=4 and 17 D0 words transferred -> cnt_D0 reads 15 then 0 then 1.
//  6. Reset asserted the cycle after a pop -> the captured word is discarded;
//     out_valid=0 and counters=0 on the next cycle.

Source files
------------

// File: rtl/pcie_dest_drain_pkg.sv
// pcie_dest_drain_pkg: source tags and skid depth shared by the drain logic
package pcie_dest_drain_pkg;
  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/pcie_dest_drain_if.sv
// pcie_dest_drain_if: FIFO pop side and merged output stream of the drain
interface pcie_dest_drain_if #(
  parameter int BITNUMBER = 6,
  parameter int COUNT_W = 8
);
  logic D0_can_pop;
  logic D1_can_pop;
  logic [BITNUMBER-1:0] data_out0;
  logic [BITNUMBER-1:0] data_out1;
  logic out_ready;
  logic pop_D0;
  logic pop_D1;
  logic [BITNUMBER-1:0] out_data;
  logic out_dest;
  logic out_valid;
  logic [COUNT_W-1:0] cnt_D0;
  logic [COUNT_W-1:0] cnt_D1;
  logic idle;
  modport slave (
    input D0_can_pop, D1_can_pop, data_out0, data_out1, out_ready,
    output pop_D0, pop_D1, out_data, out_dest, out_valid, cnt_D0, cnt_D1, idle
  );
  modport master (
    output D0_can_pop, D1_can_pop, data_out0, data_out1, out_ready,
    input pop_D0, pop_D1, out_data, out_dest, out_valid, cnt_D0, cnt_D1, idle
  );
endinterface

// File: rtl/pcie_rr_arb2.sv
// pcie_rr_arb2: 2-way round-robin grant with last-granted pointer
module pcie_rr_arb2
  import pcie_dest_drain_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  localparam logic [0:0] G_D0 = DEST_D0;
  localparam logic [0:0] G_D1 = DEST_D1;
  logic [0:0] g_q, g_d;
  // grant the lone requester, or the side that was not granted last
  always_comb begin
    gnt0 = en && req0 && (!req1 || g_q == G_D1);
    gnt1 = en && req1 && (!req0 || g_q == G_D0);
    g_d = gnt0 ? G_D0 : gnt1 ? G_D1 : g_q;
  end
  // pointer starts as if D1 was last served so D0 wins first
  always_ff @(posedge clk) begin
    if (reset) g_q <= G_D1;
    else g_q <= g_d;
  end
endmodule

// File: rtl/pcie_dest_drain.sv
// pcie_dest_drain: drains D0/D1 FIFOs into one tagged valid/ready stream
module pcie_dest_drain
  import pcie_dest_drain_pkg::*;
#(
  parameter int BITNUMBER = 6,
  parameter int COUNT_W = 8
) (
  input logic clk,
  input logic reset,
  pcie_dest_drain_if.slave bus
);
  localparam int W = BITNUMBER + 1;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d, e0_x, in_w;
  logic [1:0] occ_q, occ_d, occ_x;
  logic inflight_q, inflight_d, fl_dest_q, fl_dest_d;
  logic [COUNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic idle_q, idle_d;
  logic xfer, credit, gnt0, gnt1;
  assign xfer = occ_q != 2'd0 && bus.out_ready;
  assign occ_x = occ_q - {1'b0, xfer};
  assign credit = !reset && (3'(occ_x) + 3'(inflight_q)) < 3'(SKID_DEPTH);
  pcie_rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .en(credit),
    .req0(bus.D0_can_pop),
    .req1(bus.D1_can_pop),
    .gnt0(gnt0),
    .gnt1(gnt1)
  );
  // skid buffer shift/capture, in-flight tracking, counters and idle
  always_comb begin
    in_w = {fl_dest_q, fl_dest_q == DEST_D1 ? bus.data_out1 : bus.data_out0};
    e0_x = xfer ? e1_q : e0_q;
    e0_d = inflight_q && occ_x == 2'd0 ? in_w : e0_x;
    e1_d = inflight_q && occ_x == 2'd1 ? in_w : e1_q;
    occ_d = occ_x + {1'b0, inflight_q};
    inflight_d = gnt0 || gnt1;
    fl_dest_d = gnt1 ? DEST_D1 : DEST_D0;
    cnt0_d = cnt0_q + COUNT_W'(xfer && e0_q[BITNUMBER] == DEST_D0);
    cnt1_d = cnt1_q + COUNT_W'(xfer && e0_q[BITNUMBER] == DEST_D1);
    idle_d = !inflight_q && occ_q == 2'd0 && !bus.D0_can_pop && !bus.D1_can_pop;
  end
  // state registers; reset drops any word in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      occ_q <= '0;
      inflight_q <= 1'b0;
      fl_dest_q <= DEST_D0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      idle_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      occ_q <= occ_d;
      inflight_q <= inflight_d;
      fl_dest_q <= fl_dest_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      idle_q <= idle_d;
    end
  end
  assign bus.pop_D0 = gnt0;
  assign bus.pop_D1 = gnt1;
  assign bus.out_valid = occ_q != 2'd0;
  assign bus.out_data = e0_q[BITNUMBER-1:0];
  assign bus.out_dest = e0_q[BITNUMBER];
  assign bus.cnt_D0 = cnt0_q;
  assign bus.cnt_D1 = cnt1_q;
  assign bus.idle = idle_q;
endmodule

// File: tb/tb_pcie_dest_drain.sv
// tb_pcie_dest_drain: random and directed checks against a word-queue model
module tb_pcie_dest_drain;
  localparam int BN = 6;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pcie_dest_drain_if #(.BITNUMBER(BN), .COUNT_W(CW)) bus ();
  pcie_dest_drain #(.BITNUMBER(BN), .COUNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0, n_fail = 0;
  logic [5:0] q0[$], q1[$];
  logic [6:0] pend[$], sbuf[$];
  int n0 = 0, n1 = 0, npops = 0;
  bit last = 1'b1, exp_idle = 1'b0, prev_rst = 1'b0, pop0_s, pop1_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void fill();
    while (q0.size() < 8) q0.push_back(6'($urandom_range(0, 63)));
    while (q1.size() < 8) q1.push_back(6'($urandom_range(0, 63)));
  endfunction

  task automatic cyc(input bit r0, input bit r1, input bit rdy);
    bit c0, c1, xf, e0, e1, nidle;
    int outst;
    logic [6:0] w;
    @(negedge clk);
    c0 = r0 && q0.size() > 0;
    c1 = r1 && q1.size() > 0;
    bus.D0_can_pop = c0;
    bus.D1_can_pop = c1;
    bus.out_ready = rdy;
    #1;
    pop0_s = bus.pop_D0;
    pop1_s = bus.pop_D1;
    npops += int'(pop0_s | pop1_s);
    if (reset) begin
      chk("rst_pops", {30'd0, pop1_s, pop0_s}, 0);
      if (prev_rst) begin
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_dest", bus.out_dest, 0);
        chk("rst_cnt0", bus.cnt_D0, 0);
        chk("rst_cnt1", bus.cnt_D1, 0);
        chk("rst_idle", bus.idle, 0);
      end
      prev_rst = 1'b1;
      @(posedge clk);
      #1;
      pend.delete();
      sbuf.delete();
      n0 = 0;
      n1 = 0;
      last = 1'b1;
      exp_idle = 1'b0;
      return;
    end
    prev_rst = 1'b0;
    xf = sbuf.size() > 0 && rdy;
    outst = sbuf.size() + pend.size() - int'(xf);
    e0 = 1'b0;
    e1 = 1'b0;
    if (outst < 2) begin
      if (c0 && c1) begin
        e0 = last;
        e1 = !last;
      end else begin
        e0 = c0;
        e1 = c1;
      end
    end
    chk("pop_D0", pop0_s, e0);
    chk("pop_D1", pop1_s, e1);
    chk("out_valid", bus.out_valid, sbuf.size() > 0);
    if (sbuf.size() > 0) begin
      chk("out_data", bus.out_data, sbuf[0][5:0]);
      chk("out_dest", bus.out_dest, sbuf[0][6]);
    end
    chk("cnt_D0", bus.cnt_D0, n0 % 16);
    chk("cnt_D1", bus.cnt_D1, n1 % 16);
    chk("idle", bus.idle, exp_idle);
    nidle = pend.size() == 0 && sbuf.size() == 0 && !c0 && !c1;
    @(posedge clk);
    #1;
    if (xf) begin
      w = sbuf.pop_front();
      if (w[6]) n1++;
      else n0++;
    end
    if (pend.size() > 0) sbuf.push_back(pend.pop_front());
    if (e0) begin
      w = {1'b0, q0.pop_front()};
      pend.push_back(w);
      bus.data_out0 = w[5:0];
      last = 1'b0;
    end
    if (e1) begin
      w = {1'b1, q1.pop_front()};
      pend.push_back(w);
      bus.data_out1 = w[5:0];
      last = 1'b1;
    end
    exp_idle = nidle;
  endtask

  task automatic do_reset(input int n, input bit c);
    reset = 1'b1;
    repeat (n) cyc(c, c, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    int d;
    bus.D0_can_pop = 1'b0;
    bus.D1_can_pop = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_out0 = '0;
    bus.data_out1 = '0;
    fill();
    do_reset(3, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t1_first_pop_D0", pop0_s, 1);
    chk("t1_first_pop_D1", pop1_s, 0);
    do_reset(1, 1'b0);
    q1.delete();
    q1.push_back(6'h15);
    repeat (5) cyc(1'b0, 1'b1, 1'b1);
    chk("t2_cnt_D1", bus.cnt_D1, 1);
    do_reset(1, 1'b0);
    repeat (30) begin
      fill();
      cyc(1'b1, 1'b1, 1'b1);
    end
    d = (int'(bus.cnt_D0) - int'(bus.cnt_D1) + 16) % 16;
    chk("t3_balance", d <= 1 || d == 15, 1);
    do_reset(1, 1'b0);
    fill();
    npops = 0;
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    chk("t4_stall_pops", npops, 2);
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    chk("t4_drained", bus.cnt_D0 + bus.cnt_D1, 2);
    do_reset(1, 1'b0);
    q0.delete();
    repeat (17) q0.push_back(6'($urandom_range(0, 63)));
    repeat (22) cyc(1'b1, 1'b0, 1'b1);
    chk("t5_wrap", bus.cnt_D0, 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    chk("idle_quiet", bus.idle, 1);
    repeat (300) begin
      fill();
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    do_reset(1, 1'b0);
    fill();
    cyc(1'b1, 1'b0, 1'b1);
    chk("t6_popped", pop0_s, 1);
    do_reset(1, 1'b0);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_cnt0", bus.cnt_D0, 0);
    chk("t6_cnt1", bus.cnt_D1, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    chk("t6_no_ghost", bus.out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
